// File: rtl/bsg_permute_box_pkg.sv
// rtl/bsg_permute_box_pkg.sv - shared helpers for the buffered permute box
//
// Purpose: select-vector helpers shared by the crossbar and the buffered wrapper.
//   identity_sel(els, sel_w) : packed vector whose slice i holds i
//   is_perm(sel, els, sel_w) : 1 when every slice is < els and no index repeats
// The vectors are carried at a fixed maximum width. Callers truncate the result
// to els*sel_w bits.
package bsg_permute_box_pkg;

  localparam int max_sel_bits_lp = 256;
  localparam int max_els_lp      = 64;

  typedef logic [max_sel_bits_lp-1:0] sel_vec_t;

  function automatic sel_vec_t identity_sel(int els, int sel_w);
    sel_vec_t r;
    r = '0;
    for (int i = 0; i < els; i++) begin
      r = r | (sel_vec_t'(i) << (i * sel_w));
    end
    return r;
  endfunction

  function automatic logic is_perm(sel_vec_t sel, int els, int sel_w);
    logic [max_els_lp-1:0] seen;
    sel_vec_t              mask;
    int                    idx;
    logic                  ok;
    seen = '0;
    ok   = 1'b1;
    mask = (sel_vec_t'(1) << sel_w) - sel_vec_t'(1);
    for (int i = 0; i < els; i++) begin
      idx = int'((sel >> (i * sel_w)) & mask);
      if (idx >= els) begin
        ok = 1'b0;
      end else if (seen[idx[5:0]]) begin
        ok = 1'b0;
      end else begin
        seen[idx[5:0]] = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bsg_permute_box.sv
// rtl/bsg_permute_box.sv - combinational element crossbar
//
// Purpose: output element i = input element select_i slice i. When a select
// index is >= els_p, that output element is 0.
// Ports:
//   data_i   : els_p*width_p input elements, element k = [k*width_p +: width_p]
//   select_i : els_p*sel_width_lp packed source indices
//   data_o   : els_p*width_p permuted elements
module bsg_permute_box
  import bsg_permute_box_pkg::*;
#(
  parameter int els_p        = 4,
  parameter int width_p      = 8,
  parameter int sel_width_lp = $clog2(els_p)
) (
  input  logic [els_p*width_p-1:0]      data_i,
  input  logic [els_p*sel_width_lp-1:0] select_i,
  output logic [els_p*width_p-1:0]      data_o
);

  // The mux is built by comparing against each legal index. Any
  // out-of-range index therefore matches nothing and keeps the zero default.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      for (int k = 0; k < els_p; k++) begin
        if (select_i[i*sel_width_lp +: sel_width_lp] == sel_width_lp'(k)) begin
          data_o[i*width_p +: width_p] = data_i[k*width_p +: width_p];
        end
      end
    end
  end

endmodule

// File: rtl/bsg_permute_box_buffered.sv
// rtl/bsg_permute_box_buffered.sv - registered permute box with 2-entry output buffer
//
// Purpose: permutes each accepted beat through a programmable select register.
// The result is stored in a 2-entry circular buffer. Each output element i
// takes input element sel[i].
// Optional macro: BSG_PERMUTE_BOX_PERM_CHECK_EN adds err_o. With it, a select
// vector that is not a bijection is rejected and err_o is set sticky.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset
//   cfg_v_i, cfg_sel_i : load a new select vector (takes effect next cycle)
//   v_i, data_i, ready_o : input handshake (enqueue on v_i & ready_o)
//   v_o, data_o, yumi_i  : output handshake (dequeue on yumi_i)
//   err_o              : sticky bad-config flag (check build only)
module bsg_permute_box_buffered
  import bsg_permute_box_pkg::*;
#(
  parameter int els_p        = 4,
  parameter int width_p      = 8,
  parameter int sel_width_lp = $clog2(els_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          cfg_v_i,
  input  logic [els_p*sel_width_lp-1:0] cfg_sel_i,
  input  logic                          v_i,
  input  logic [els_p*width_p-1:0]      data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [els_p*width_p-1:0]      data_o,
`ifdef BSG_PERMUTE_BOX_PERM_CHECK_EN
  output logic                          err_o,
`endif
  input  logic                          yumi_i
);

  localparam int       sel_bits_lp   = els_p * sel_width_lp;
  localparam sel_vec_t id_full_lp    = identity_sel(els_p, sel_width_lp);
  localparam logic [sel_bits_lp-1:0] sel_reset_lp = id_full_lp[sel_bits_lp-1:0];

  logic [sel_bits_lp-1:0]   sel_q, sel_d;
  logic [els_p*width_p-1:0] mem_q [2];
  logic                     head_q, head_d;
  logic                     tail_q, tail_d;
  logic [1:0]               count_q, count_d;
  logic [els_p*width_p-1:0] perm_data;
  logic                     enq, deq, cfg_load;

  // The crossbar sits before the buffer, so the outputs come only from registers.
  bsg_permute_box #(
    .els_p        (els_p),
    .width_p      (width_p),
    .sel_width_lp (sel_width_lp)
  ) u_xbar (
    .data_i   (data_i),
    .select_i (sel_q),
    .data_o   (perm_data)
  );

  assign ready_o = (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[head_q];
  assign enq     = v_i & ready_o;
  // An illegal yumi with an empty buffer is masked, so state does not move.
  assign deq     = yumi_i & v_o;

`ifdef BSG_PERMUTE_BOX_PERM_CHECK_EN
  logic err_q, err_d;
  logic cfg_ok;
  assign cfg_ok   = is_perm(sel_vec_t'(cfg_sel_i), els_p, sel_width_lp);
  assign cfg_load = cfg_v_i & cfg_ok;
  assign err_d    = err_q | (cfg_v_i & ~cfg_ok);
  assign err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  assign cfg_load = cfg_v_i;
`endif

  always_comb begin
    sel_d   = sel_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (cfg_load) sel_d = cfg_sel_i;
    if (enq) tail_d = ~tail_q;
    if (deq) head_d = ~head_q;
    if (enq && !deq)      count_d = count_q + 2'd1;
    else if (deq && !enq) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q    <= sel_reset_lp;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      sel_q   <= sel_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) mem_q[tail_q] <= perm_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("bsg_permute_box_buffered: yumi_i asserted while v_o=0");
    end
  end

endmodule
